// File: rtl/sub_scheduler.sv
// Round-robin scheduler sharing one saturating I/Q subtractor among N_CH channels.
// Tracks in-flight operations by channel tag and returns results through a credit-protected FWFT FIFO.
module sub_scheduler #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned SUB_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      M100CLK,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_CH-1:0]           req_valid,
  input  logic [N_CH*DW-1:0]        req_i,
  input  logic [N_CH*DW-1:0]        req_q,
  output logic [N_CH-1:0]           req_ready,
  output logic [DW-1:0]             sub_i,
  output logic [DW-1:0]             sub_q,
  input  logic [DW:0]               sub_sum,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DW:0]               res_data,
  output logic [$clog2(N_CH)-1:0]   res_ch,
  output logic                      busy
);

  localparam int unsigned CW   = $clog2(N_CH);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NW   = AW + 2;
  localparam int unsigned IW   = $clog2(SUB_LAT + 1);
  localparam int unsigned LAST = SUB_LAT - 1;

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    grant_ch;
  logic [CW-1:0]    idx;
  logic             found;
  logic             credit_ok;
  logic             issue;
  logic [IW-1:0]    inflight;

  logic [SUB_LAT-1:0] tag_vld;
  logic [CW-1:0]      tag_ch [SUB_LAT];

  logic [DW:0]      mem_data [FIFO_DEPTH];
  logic [CW-1:0]    mem_ch   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Number of operations currently travelling through the subtractor.
  always_comb begin
    inflight = '0;
    for (int unsigned s = 0; s < SUB_LAT; s++) begin
      inflight = inflight + IW'(tag_vld[s]);
    end
  end

  // Round-robin search starting at the priority pointer.
  always_comb begin
    found    = 1'b0;
    grant_ch = '0;
    idx      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = ptr + CW'(k);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_ch = idx;
      end
    end
  end

  // A same-cycle pop is not credited, so a queued entry always has a FIFO slot reserved.
  assign credit_ok = (NW'(count) + NW'(inflight)) < NW'(FIFO_DEPTH);
  assign issue     = enable && found && credit_ok && !reset;
  assign req_ready = issue ? (N_CH'(1) << grant_ch) : '0;

  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      sub_i   <= '0;
      sub_q   <= '0;
      tag_vld <= '0;
      for (int unsigned s = 0; s < SUB_LAT; s++) begin
        tag_ch[s] <= '0;
      end
    end else begin
      if (issue) begin
        ptr   <= grant_ch + CW'(1);
        sub_i <= req_i[grant_ch*DW +: DW];
        sub_q <= req_q[grant_ch*DW +: DW];
      end
      tag_vld[0] <= issue;
      tag_ch[0]  <= grant_ch;
      for (int unsigned s = 1; s < SUB_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_ch[s]  <= tag_ch[s-1];
      end
    end
  end

  assign push      = tag_vld[LAST];
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;

  // Result storage; contents are only observed through a non-empty head.
  always_ff @(posedge M100CLK) begin
    if (push) begin
      mem_data[wr_ptr] <= sub_sum;
      mem_ch[wr_ptr]   <= tag_ch[LAST];
    end
  end

  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign res_data = res_valid ? mem_data[rd_ptr] : '0;
  assign res_ch   = res_valid ? mem_ch[rd_ptr]   : '0;
  assign busy     = (|tag_vld) || res_valid;

endmodule

// File: tb/tb_sub_scheduler.sv
// Directed bench for sub_scheduler: vector table plus fairness, backpressure, enable and reset sequences.
module tb_sub_scheduler;

  localparam int unsigned N_CH       = 4;
  localparam int unsigned DW         = 32;
  localparam int unsigned SUB_LAT    = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CW         = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [N_CH-1:0]      req_valid;
  logic [N_CH*DW-1:0]   req_i;
  logic [N_CH*DW-1:0]   req_q;
  logic [N_CH-1:0]      req_ready;
  logic [DW-1:0]        sub_i;
  logic [DW-1:0]        sub_q;
  logic [DW:0]          sub_sum;
  logic                 res_valid;
  logic                 res_ready;
  logic [DW:0]          res_data;
  logic [CW-1:0]        res_ch;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  sub_scheduler #(.N_CH(N_CH), .DW(DW), .SUB_LAT(SUB_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .M100CLK(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_i(req_i), .req_q(req_q), .req_ready(req_ready),
    .sub_i(sub_i), .sub_q(sub_q), .sub_sum(sub_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Saturating subtractor model; bit DW carries the sign of the saturated result.
  function automatic logic [DW:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    if (!d[DW] && d[DW-1])      return {2'b00, {(DW-1){1'b1}}};
    else if (d[DW] && !d[DW-1]) return {2'b11, {(DW-1){1'b0}}};
    else                        return d;
  endfunction

  // One register stage before the push point gives the SUB_LAT=2 edge alignment.
  logic [DW:0] sub_pipe = '0;
  always @(posedge clk) sub_pipe <= sat_sub(sub_i, sub_q);
  assign sub_sum = sub_pipe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [CW-1:0] ch;
    logic [DW:0]   data;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: record each accepted request, compare each popped result in order.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got ch=%0d data=%0h expected no result", res_ch, res_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (res_data !== e.data || res_ch !== e.ch) begin
            n_fail++;
            $display("FAIL pop_order: got ch=%0d data=%0h expected ch=%0d data=%0h",
                     res_ch, res_data, e.ch, e.data);
          end
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          exp_t e;
          e.ch   = CW'(c);
          e.data = sat_sub(req_i[c*DW +: DW], req_q[c*DW +: DW]);
          sb.push_back(e);
        end
      end
    end
  end

  typedef struct {
    int          ch;
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic [DW:0]   sum;
  } vec_t;
  vec_t vecs[4];

  task automatic drain(input string name);
    int n;
    req_valid = '0;
    res_ready = 1'b1;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  initial begin
    int grants;
    int resumed;

    vecs[0] = '{ch: 2, i: 32'd100,        q: 32'd40,         sum: 33'h0_0000003C};
    vecs[1] = '{ch: 0, i: 32'h7FFFFFFF,   q: 32'hFFFFFFFF,   sum: 33'h0_7FFFFFFF};
    vecs[2] = '{ch: 1, i: 32'd5,          q: 32'd10,         sum: 33'h1_FFFFFFFB};
    vecs[3] = '{ch: 3, i: 32'h80000000,   q: 32'd1,          sum: 33'h1_80000000};

    reset = 1'b1; enable = 1'b1; req_valid = 4'hF; res_ready = 1'b0;
    req_i = {N_CH*DW{1'b1}}; req_q = '0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_sub_i",     64'(sub_i),     64'd0);
    check("rst_res_data",  64'(res_data),  64'd0);
    check("rst_res_ch",    64'(res_ch),    64'd0);
    tick();
    reset = 1'b0; req_valid = '0; req_i = '0;
    tick();

    // Single-request vectors through the full latency.
    for (int v = 0; v < 4; v++) begin
      req_valid = N_CH'(1) << vecs[v].ch;
      req_i[vecs[v].ch*DW +: DW] = vecs[v].i;
      req_q[vecs[v].ch*DW +: DW] = vecs[v].q;
      #1;
      check($sformatf("v%0d_grant", v), 64'(req_ready), 64'(N_CH'(1) << vecs[v].ch));
      tick();
      req_valid = '0;
      #1;
      check($sformatf("v%0d_ready_drop", v), 64'(req_ready), 64'd0);
      check($sformatf("v%0d_sub_i", v), 64'(sub_i), 64'(vecs[v].i));
      check($sformatf("v%0d_sub_q", v), 64'(sub_q), 64'(vecs[v].q));
      check($sformatf("v%0d_early", v), 64'(res_valid), 64'd0);
      tick();
      check($sformatf("v%0d_early2", v), 64'(res_valid), 64'd0);
      tick();
      check($sformatf("v%0d_valid", v), 64'(res_valid), 64'd1);
      check($sformatf("v%0d_data", v), 64'(res_data), 64'(vecs[v].sum));
      check($sformatf("v%0d_ch", v), 64'(res_ch), 64'(vecs[v].ch));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check($sformatf("v%0d_empty", v), 64'(res_valid), 64'd0);
      check($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
    end

    // Fairness: all channels requesting, pointer starts at 0 after ch3.
    for (int c = 0; c < N_CH; c++) begin
      req_i[c*DW +: DW] = DW'(1000 + c);
      req_q[c*DW +: DW] = DW'(c * 7);
    end
    req_valid = 4'hF; res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(N_CH'(1) << (k % N_CH)));
      tick();
    end
    drain("rr_drain");

    // Backpressure: credits limit total grants to FIFO_DEPTH.
    res_ready = 1'b0; req_valid = 4'hF; grants = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req_ready != '0) grants++;
      tick();
    end
    check("bp_grants", 64'(grants), 64'(FIFO_DEPTH));
    check("bp_res_valid", 64'(res_valid), 64'd1);
    res_ready = 1'b1; resumed = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (req_ready != '0) resumed = 1;
      tick();
    end
    check("bp_resume", 64'(resumed), 64'd1);
    drain("bp_drain");

    // enable dropped one cycle after a grant.
    res_ready = 1'b0; enable = 1'b1; req_valid = 4'b0010;
    #1;
    check("en_grant", 64'(req_ready), 64'b0010);
    tick();
    enable = 1'b0;
    #1;
    check("en_off0", 64'(req_ready), 64'd0);
    tick();
    check("en_off1", 64'(req_ready), 64'd0);
    tick();
    check("en_valid", 64'(res_valid), 64'd1);
    check("en_ch", 64'(res_ch), 64'd1);
    check("en_busy", 64'(busy), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("en_busy_fall", 64'(busy), 64'd0);
    check("en_no_more", 64'(req_ready), 64'd0);
    req_valid = '0; enable = 1'b1;
    tick();

    // Asynchronous reset with work in flight and queued.
    for (int c = 0; c < N_CH; c++) begin
      req_i[c*DW +: DW] = DW'(32'h100 + c);
      req_q[c*DW +: DW] = DW'(c);
    end
    res_ready = 1'b0; req_valid = 4'hF;
    tick(); tick(); tick();
    check("ar_pre_busy", 64'(busy), 64'd1);
    check("ar_pre_valid", 64'(res_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_req_ready", 64'(req_ready), 64'd0);
    check("ar_res_valid", 64'(res_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_sub_i", 64'(sub_i), 64'd0);
    check("ar_sub_q", 64'(sub_q), 64'd0);
    check("ar_res_data", 64'(res_data), 64'd0);
    check("ar_res_ch", 64'(res_ch), 64'd0);
    tick();
    reset = 1'b0; res_ready = 1'b1;
    #1;
    check("ar_first_grant", 64'(req_ready), 64'b0001);
    tick();
    check("ar_no_stale", 64'(res_valid), 64'd0);
    tick(); tick(); tick();
    drain("ar_drain");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
